// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter state encoding and transmitter byte width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // The transmitter is fixed at one byte per frame.
  localparam int UART_DATA_W = 8;

  // Width of the arbiter's "wait for tx_active" counter; covers ACK_TIMEOUT up to 255.
  localparam int ARB_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE        = 2'd0,
    ARB_ISSUE       = 2'd1,
    ARB_WAIT_ACTIVE = 2'd2,
    ARB_WAIT_DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bundle around the TX arbiter.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake on the requester side; tx_active/tx_done on the transmitter side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = UART_DATA_W
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_sent;
  logic                    tx_data_avail;
  logic [DATA_W-1:0]       tx_data_byte;
  logic                    tx_active;
  logic                    tx_done;

  // Arbiter side: accepts bytes and drives the transmitter.
  modport master (
    input  req_valid, req_data, tx_active, tx_done,
    output req_ready, req_sent, tx_data_avail, tx_data_byte
  );

  // Environment side: requesters plus the transmitter.
  modport slave (
    output req_valid, req_data, tx_active, tx_done,
    input  req_ready, req_sent, tx_data_avail, tx_data_byte
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin priority selector: first set request strictly after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk candidates from farthest to nearest so the nearest valid one after last_grant wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(last_grant) + k) % N_REQ]) begin
        idx = IDX_W'((int'(last_grant) + k) % N_REQ);
        any = 1'b1;
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers.
// Latency: accept at T, tx_data_avail at T+1; req_sent one cycle after tx_done.
// Backpressure: req_ready only in IDLE with the transmitter idle; one byte in flight at a time.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = UART_DATA_W,
  parameter  int ACK_TIMEOUT = 16,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.master bus,
  output logic [IDX_W-1:0]  grant_id,
  output logic              busy,
  output logic              err_timeout
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [ARB_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   tx_avail_q, tx_avail_d;
  logic [N_REQ-1:0]       req_sent_q, req_sent_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   busy_q, busy_d;
  // Low for the first cycle after reset so req_ready reads 0 throughout reset.
  logic                   run_q, run_d;

  logic [N_REQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   arb_open;
  logic                   handshake;
  logic [DATA_W-1:0]      pick_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .gnt        (pick_gnt),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Offer the pick only while idle and the transmitter is not still shifting.
  always_comb begin
    arb_open  = run_q && (state_q == ARB_IDLE) && !bus.tx_active;
    handshake = arb_open && pick_any;
    pick_data = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
  end

  assign bus.req_ready     = arb_open ? pick_gnt : '0;
  assign bus.req_sent      = req_sent_q;
  assign bus.tx_data_avail = tx_avail_q;
  assign bus.tx_data_byte  = data_q;
  assign grant_id          = grant_id_q;
  assign busy              = busy_q;
  assign err_timeout       = err_timeout_q;

  // Next-state and pulse generation for the accept/issue/track sequence.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    tx_avail_d    = 1'b0;
    req_sent_d    = '0;
    err_timeout_d = 1'b0;
    run_d         = 1'b1;
    unique case (state_q)
      ARB_IDLE: begin
        if (handshake) begin
          data_d     = pick_data;
          grant_id_d = pick_idx;
          tx_avail_d = 1'b1;
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT_ACTIVE;
      end
      ARB_WAIT_ACTIVE: begin
        // tx_done here is ignored: only tx_active proves the frame started.
        if (bus.tx_active) begin
          state_d = ARB_WAIT_DONE;
        end else if (cnt_q == ARB_CNT_W'(ACK_TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          last_grant_d  = grant_id_q;
          cnt_d         = '0;
          state_d       = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + ARB_CNT_W'(1);
        end
      end
      ARB_WAIT_DONE: begin
        // A tx_active drop without tx_done is not treated as completion.
        if (bus.tx_done) begin
          req_sent_d[grant_id_q] = 1'b1;
          last_grant_d           = grant_id_q;
          state_d                = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and datapath registers; requester 0 gets first priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= IDX_W'(N_REQ - 1);
      grant_id_q    <= '0;
      data_q        <= '0;
      cnt_q         <= '0;
      tx_avail_q    <= 1'b0;
      req_sent_q    <= '0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      data_q        <= data_d;
      cnt_q         <= cnt_d;
      tx_avail_q    <= tx_avail_d;
      req_sent_q    <= req_sent_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
      run_q         <= run_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_arbiter;

  localparam int ACK_TO = 16;
  localparam int FRAME  = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       busy;
  logic       err_timeout;

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0 normal transmitter, 1 stalled, 2 tx_done without tx_active

  // Transmitter model, acting 1 time unit after each rising edge.
  initial begin
    int  fcnt;
    int  bcnt;
    bit  pend;
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    fcnt = 0;
    bcnt = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        fcnt = 0;
        bcnt = 0;
        pend = 1'b0;
      end else begin
        bus.tx_done = 1'b0;
        if (pend) begin
          bus.tx_active = 1'b1;
          fcnt = FRAME;
          pend = 1'b0;
        end else if (bus.tx_active) begin
          fcnt--;
          if (fcnt == 0) begin
            bus.tx_active = 1'b0;
            bus.tx_done   = 1'b1;
          end
        end
        if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0) bus.tx_done = 1'b1;
        end
        if (bus.tx_data_avail) begin
          if (mode == 0) pend = 1'b1;
          else if (mode == 2) bcnt = 3;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  // One complete frame through the normal transmitter model.
  task automatic run_frame(input logic [3:0] v, input logic [31:0] d, input int exp_idx,
                           input logic [7:0] exp_b);
    logic [3:0] exp_oh;
    bit         got;
    int         extra;
    exp_oh = 4'b0001 << exp_idx;
    bus.req_valid = v;
    bus.req_data  = d;
    #1;
    chk("ready_onehot", bus.req_ready, exp_oh);
    chk("busy_idle", busy, 0);
    step();
    bus.req_valid = '0;
    chk("avail_pulse", bus.tx_data_avail, 1);
    chk("tx_byte", bus.tx_data_byte, exp_b);
    chk("grant_id", grant_id, exp_idx);
    chk("busy_frame", busy, 1);
    got   = 1'b0;
    extra = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      step();
      if (bus.tx_data_avail) extra++;
      if (bus.req_sent != 0) got = 1'b1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL sent_wait: no req_sent within 30 cycles, expected %0h", exp_oh);
    end else begin
      chk("req_sent", bus.req_sent, exp_oh);
      chk("busy_after_sent", busy, 0);
      chk("extra_avail", extra, 0);
    end
  endtask

  // A frame the transmitter never starts; expects a timeout and no completion.
  task automatic run_stall(input int m, input logic [3:0] v, input logic [31:0] d, input int exp_idx,
                           input logic [3:0] v_after, input logic [3:0] exp_next);
    int got;
    bit sent_seen;
    mode = m;
    bus.req_valid = v;
    bus.req_data  = d;
    #1;
    chk("stall_ready", bus.req_ready, 4'b0001 << exp_idx);
    step();
    chk("stall_avail", bus.tx_data_avail, 1);
    bus.req_valid = v_after;
    got = -1;
    sent_seen = 1'b0;
    for (int n = 1; n <= 40 && got < 0; n++) begin
      step();
      if (bus.req_sent != 0) sent_seen = 1'b1;
      if (err_timeout) got = n;
    end
    chk("timeout_delay", got, ACK_TO + 1);
    chk("no_sent_on_timeout", sent_seen, 0);
    chk("next_rr_ready", bus.req_ready, exp_next);
    bus.req_valid = '0;
    step();
    chk("err_single_cycle", err_timeout, 0);
    chk("idle_after_timeout", busy, 0);
    mode = 0;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_idx;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int navail;
    int sent;
    int viol;
    int gs[5];
    logic [7:0] bs[5];
    int exp_seq[5];

    // Round-robin sequence starting from last_grant = 3 after reset.
    vecs[0] = '{4'b0100, 32'h00A50000, 2, 8'hA5};
    vecs[1] = '{4'b1111, 32'h44332211, 3, 8'h44};
    vecs[2] = '{4'b1111, 32'h44332211, 0, 8'h11};
    vecs[3] = '{4'b0011, 32'h44332211, 1, 8'h22};
    vecs[4] = '{4'b0001, 32'h44332211, 0, 8'h11};
    vecs[5] = '{4'b1010, 32'h44332211, 1, 8'h22};
    vecs[6] = '{4'b1001, 32'h44332211, 3, 8'h44};
    vecs[7] = '{4'b1001, 32'h44332211, 0, 8'h11};

    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    step();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_sent", bus.req_sent, 0);
    chk("rst_avail", bus.tx_data_avail, 0);
    chk("rst_byte", bus.tx_data_byte, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    step();
    step();

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].valid, vecs[i].data, vecs[i].exp_idx, vecs[i].exp_byte);
    end

    // Requester 1 withdraws before its handshake; 3 is taken instead, 1 follows.
    bus.req_valid = 4'b1010;
    bus.req_data  = 32'h44332211;
    #1;
    chk("drop_pre_ready", bus.req_ready, 4'b0010);
    bus.req_valid = 4'b1000;
    #1;
    chk("drop_post_ready", bus.req_ready, 4'b1000);
    run_frame(4'b1000, 32'h44332211, 3, 8'h44);
    run_frame(4'b1010, 32'h44332211, 1, 8'h22);

    // Stalled transmitter, then tx_done with no tx_active.
    run_stall(1, 4'b1101, 32'h44332211, 2, 4'b1001, 4'b1000);
    run_frame(4'b1000, 32'h44332211, 3, 8'h44);
    run_stall(2, 4'b0001, 32'h44332211, 0, 4'b0010, 4'b0010);

    // Reset while waiting for tx_done.
    bus.req_valid = 4'b0100;
    bus.req_data  = 32'h005A0000;
    #1;
    chk("mid_ready", bus.req_ready, 4'b0100);
    step();
    bus.req_valid = 4'b1000;
    begin
      bit act;
      act = 1'b0;
      for (int n = 0; n < 10 && !act; n++) begin
        step();
        act = bus.tx_active;
      end
      chk("mid_tx_active_seen", act, 1);
    end
    step();
    chk("mid_busy", busy, 1);
    chk("mid_grant", grant_id, 2);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", bus.req_ready, 0);
    chk("mrst_sent", bus.req_sent, 0);
    chk("mrst_avail", bus.tx_data_avail, 0);
    chk("mrst_byte", bus.tx_data_byte, 0);
    chk("mrst_grant", grant_id, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err_timeout, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    bus.req_valid = 4'b1001;
    #1;
    chk("post_rst_prio0", bus.req_ready, 4'b0001);
    run_frame(4'b1000, 32'h77000000, 3, 8'h77);

    // All requesters valid continuously from reset.
    do_reset();
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h13121110;
    exp_seq = '{0, 1, 2, 3, 0};
    navail = 0;
    sent   = 0;
    viol   = 0;
    for (int c = 0; c < 300 && navail < 5; c++) begin
      step();
      if (bus.tx_active && (bus.req_ready != 0)) viol++;
      if (bus.req_sent != 0) sent++;
      if (bus.tx_data_avail) begin
        gs[navail] = int'(grant_id);
        bs[navail] = bus.tx_data_byte;
        navail++;
      end
    end
    bus.req_valid = '0;
    chk("cont_avail_count", navail, 5);
    for (int i = 0; i < 5; i++) begin
      chk("cont_grant_order", gs[i], exp_seq[i]);
      chk("cont_byte", bs[i], 8'h10 + 8'(exp_seq[i]));
    end
    chk("cont_sent_count", sent, 4);
    chk("cont_accept_while_active", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
